// File: rtl/instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// instr_fetch_unit : PC owner, single-outstanding imem reads, {pc,word} FIFO
// Optional feature macro: FETCH_MISALIGN_TRAP_EN (misaligned redirect -> HALT)
// Revision: 1.0
// ============================================================================
module instr_fetch_unit #(
    parameter logic [31:0] RESET_ADDR = 32'h00400000,
    parameter int          DEPTH      = 2
) (
    input  logic        clk,
    input  logic        rst_n,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic        instr_valid,
    input  logic        instr_ready,
    output logic [31:0] instr,
    output logic [31:0] instr_pc,
    input  logic        redirect,
    input  logic [31:0] redirect_pc
`ifdef FETCH_MISALIGN_TRAP_EN
    ,
    output logic        fault
`endif
);

    localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CW = $clog2(DEPTH + 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_DROP = 2'd2,
        S_HALT = 2'd3
    } state_t;

    state_t        state_q, state_d;
    logic [31:0]   pc_q, pc_d;
    logic [31:0]   req_pc_q, req_pc_d;
    logic [CW-1:0] count_q, count_d;
    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic [PW-1:0] wr_ptr_q, wr_ptr_d;
    logic [31:0]   fifo_pc_q   [DEPTH];
    logic [31:0]   fifo_word_q [DEPTH];
`ifdef FETCH_MISALIGN_TRAP_EN
    logic          fault_q, fault_d;
`endif

    logic          pop;
    logic          push;
    logic          issue;
    logic          misalign;
    logic [CW:0]   occ;
    logic [31:0]   redirect_aligned;

    always_comb begin
        redirect_aligned = redirect_pc & 32'hFFFF_FFFC;
`ifdef FETCH_MISALIGN_TRAP_EN
        misalign = (redirect_pc[1:0] != 2'b00);
`else
        misalign = 1'b0;
`endif
        pop   = instr_valid && instr_ready;
        // Occupancy the FIFO will need if one more word is requested now.
        occ   = {1'b0, count_q} + {{CW{1'b0}}, (state_q == S_WAIT)} - {{CW{1'b0}}, pop};
        issue = !redirect
              && ((state_q == S_IDLE) || ((state_q == S_WAIT) && imem_rvalid))
              && (occ < (CW+1)'(DEPTH));
        push  = !redirect && (state_q == S_WAIT) && imem_rvalid;

        state_d  = state_q;
        pc_d     = pc_q;
        req_pc_d = req_pc_q;
        count_d  = count_q;
        rd_ptr_d = rd_ptr_q;
        wr_ptr_d = wr_ptr_q;
`ifdef FETCH_MISALIGN_TRAP_EN
        fault_d  = fault_q;
`endif

        if (state_q != S_HALT) begin
            if (redirect) begin
                count_d  = '0;
                rd_ptr_d = '0;
                wr_ptr_d = '0;
                pc_d     = redirect_aligned;
                if (misalign) begin
                    state_d = S_HALT;
`ifdef FETCH_MISALIGN_TRAP_EN
                    fault_d = 1'b1;
`endif
                end else if (state_q != S_IDLE) begin
                    state_d = imem_rvalid ? S_IDLE : S_DROP;
                end
            end else begin
                if (pop) begin
                    rd_ptr_d = rd_ptr_q + PW'(1);
                end
                if (push) begin
                    wr_ptr_d = wr_ptr_q + PW'(1);
                end
                case ({push, pop})
                    2'b10:   count_d = count_q + CW'(1);
                    2'b01:   count_d = count_q - CW'(1);
                    default: count_d = count_q;
                endcase
                if (issue) begin
                    state_d  = S_WAIT;
                    req_pc_d = pc_q;
                    pc_d     = pc_q + 32'd4;
                end else if (imem_rvalid && (state_q != S_IDLE)) begin
                    state_d = S_IDLE;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= S_IDLE;
            pc_q     <= RESET_ADDR;
            req_pc_q <= '0;
            count_q  <= '0;
            rd_ptr_q <= '0;
            wr_ptr_q <= '0;
            for (int i = 0; i < DEPTH; i++) begin
                fifo_pc_q[i]   <= '0;
                fifo_word_q[i] <= '0;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q  <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            pc_q     <= pc_d;
            req_pc_q <= req_pc_d;
            count_q  <= count_d;
            rd_ptr_q <= rd_ptr_d;
            wr_ptr_q <= wr_ptr_d;
            if (push) begin
                fifo_pc_q[wr_ptr_q]   <= req_pc_q;
                fifo_word_q[wr_ptr_q] <= imem_rdata;
            end
`ifdef FETCH_MISALIGN_TRAP_EN
            fault_q  <= fault_d;
`endif
        end
    end

    // Request is held off while reset is asserted even though the FSM sits in IDLE.
    assign imem_req    = issue && rst_n;
    assign imem_addr   = pc_q;
    assign instr_valid = (count_q != '0);
    assign instr       = fifo_word_q[rd_ptr_q];
    assign instr_pc    = fifo_pc_q[rd_ptr_q];
`ifdef FETCH_MISALIGN_TRAP_EN
    assign fault       = fault_q;
`endif

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_unit.sv
`default_nettype none
// ============================================================================
// tb_instr_fetch_unit : randomized bench with a transaction-level fetch model
// Revision: 1.0
// ============================================================================
module tb_instr_fetch_unit;

    localparam logic [31:0] RESET_ADDR = 32'h00400000;
    localparam int          DEPTH      = 2;

    logic        clk         = 1'b0;
    logic        rst_n       = 1'b0;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata  = '0;
    logic        instr_valid;
    logic        instr_ready = 1'b0;
    logic [31:0] instr;
    logic [31:0] instr_pc;
    logic        redirect    = 1'b0;
    logic [31:0] redirect_pc = '0;
`ifdef FETCH_MISALIGN_TRAP_EN
    logic        fault;
`endif

    instr_fetch_unit #(
        .RESET_ADDR (RESET_ADDR),
        .DEPTH      (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .instr       (instr),
        .instr_pc    (instr_pc),
        .redirect    (redirect),
        .redirect_pc (redirect_pc)
`ifdef FETCH_MISALIGN_TRAP_EN
        ,
        .fault       (fault)
`endif
    );

    always #5 clk = ~clk;

    // Model: queue of words the core should see, plus one memory-side request slot.
    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] word;
    } ent_t;

    ent_t        mq[$];
    bit          pend       = 1'b0;
    logic [31:0] pend_addr  = '0;
    int          pend_epoch = 0;
    int          pend_wait  = 0;
    int          epoch      = 0;
    logic [31:0] next_pc    = RESET_ADDR;
    bit          halted     = 1'b0;
    bit          fault_exp  = 1'b0;
    int          lat_min    = 1;
    int          lat_max    = 1;
    int          n_tests    = 0;
    int          n_fail     = 0;
    int          n_pops     = 0;

    function automatic logic [31:0] word_of(input logic [31:0] a);
        return {a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // Entered at posedge+1: drive inputs, sample at the falling edge, advance model.
    task automatic do_cycle(input bit rdy, input bit redir, input logic [31:0] rpc);
        bit exp_valid, live_pend, live_resp, exp_pop, exp_req, misal;
        if (pend && pend_wait == 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = word_of(pend_addr);
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = $urandom;
            if (pend) pend_wait--;
        end
        instr_ready = rdy;
        redirect    = redir;
        redirect_pc = rpc;
        #4;
        exp_valid = (mq.size() != 0);
        check_eq("instr_valid", 32'(instr_valid), 32'(exp_valid));
        if (exp_valid) begin
            check_eq("instr_pc", instr_pc, mq[0].pc);
            check_eq("instr", instr, mq[0].word);
        end
        live_pend = pend && (pend_epoch == epoch);
        live_resp = imem_rvalid && live_pend;
        exp_pop   = exp_valid && rdy;
        exp_req   = !halted && !redir && (!pend || live_resp)
                    && ((mq.size() + int'(live_pend) - int'(exp_pop)) < DEPTH);
        check_eq("imem_req", 32'(imem_req), 32'(exp_req));
        if (exp_req) check_eq("imem_addr", imem_addr, next_pc);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("fault", 32'(fault), 32'(fault_exp));
        misal = (rpc[1:0] != 2'b00);
`else
        misal = 1'b0;
`endif
        if (imem_rvalid) pend = 1'b0;
        if (instr_valid && rdy) n_pops++;
        if (!halted) begin
            if (redir) begin
                mq.delete();
                epoch++;
                if (misal) begin
                    halted    = 1'b1;
                    fault_exp = 1'b1;
                end else begin
                    next_pc = rpc & 32'hFFFF_FFFC;
                end
            end else begin
                if (exp_pop) void'(mq.pop_front());
                if (live_resp) begin
                    check_eq("fifo_no_overflow", 32'(mq.size() < DEPTH), 32'd1);
                    mq.push_back({pend_addr, word_of(pend_addr)});
                end
                if (exp_req) begin
                    pend       = 1'b1;
                    pend_addr  = next_pc;
                    pend_epoch = epoch;
                    pend_wait  = int'($urandom_range(lat_max, lat_min)) - 1;
                    next_pc    = next_pc + 32'd4;
                end
            end
        end
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        imem_rvalid = 1'b0;
        redirect    = 1'b0;
        instr_ready = 1'b0;
        rst_n       = 1'b0;
        #1;
        check_eq("rst_imem_req", 32'(imem_req), 32'd0);
        check_eq("rst_imem_addr", imem_addr, RESET_ADDR);
        check_eq("rst_instr_valid", 32'(instr_valid), 32'd0);
        check_eq("rst_instr", instr, 32'd0);
        check_eq("rst_instr_pc", instr_pc, 32'd0);
`ifdef FETCH_MISALIGN_TRAP_EN
        check_eq("rst_fault", 32'(fault), 32'd0);
`endif
        mq.delete();
        pend      = 1'b0;
        epoch++;
        next_pc   = RESET_ADDR;
        halted    = 1'b0;
        fault_exp = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int first, p0, k;
        logic [31:0] rpc;
        @(posedge clk);
        #1;
        do_reset();

        // Fill latency and single-cycle throughput with 1-cycle memory.
        lat_min = 1; lat_max = 1;
        first = -1;
        p0 = n_pops;
        for (int i = 0; i < 12; i++) begin
            k = n_pops;
            do_cycle(1'b1, 1'b0, 32'd0);
            if (first < 0 && n_pops > k) first = i;
        end
        check_eq("fill_latency", 32'(first), 32'd2);
        check_eq("throughput", 32'(n_pops - p0), 32'd10);

        // Backpressure then release.
        repeat (6) do_cycle(1'b0, 1'b0, 32'd0);
        check_eq("bp_req_low", 32'(imem_req), 32'd0);
        repeat (10) do_cycle(1'b1, 1'b0, 32'd0);

        // Redirect while a 3-cycle request is outstanding.
        lat_min = 3; lat_max = 3;
        k = 0;
        while (!(pend && pend_wait > 0) && k < 50) begin
            do_cycle(1'b1, 1'b0, 32'd0);
            k++;
        end
        check_eq("t_outstanding_seen", 32'(pend && pend_wait > 0), 32'd1);
        do_cycle(1'b1, 1'b1, 32'h00400100);
        repeat (15) do_cycle(1'b1, 1'b0, 32'd0);

        // Redirect coinciding with a response and a pop.
        lat_min = 1; lat_max = 1;
        k = 0;
        while (!(pend && pend_wait == 0 && mq.size() != 0) && k < 50) begin
            do_cycle(1'b1, 1'b0, 32'd0);
            k++;
        end
        check_eq("t_rvalid_pop_seen", 32'(pend && pend_wait == 0 && mq.size() != 0), 32'd1);
        do_cycle(1'b1, 1'b1, 32'h00400200);
        repeat (8) do_cycle(1'b1, 1'b0, 32'd0);

        // Reset with a response in flight.
        lat_min = 3; lat_max = 3;
        k = 0;
        while (!pend && k < 50) begin
            do_cycle(1'b1, 1'b0, 32'd0);
            k++;
        end
        do_reset();
        repeat (10) do_cycle(1'b1, 1'b0, 32'd0);

        // Misaligned redirect.
        lat_min = 1; lat_max = 2;
        do_cycle(1'b1, 1'b1, 32'h00400102);
`ifdef FETCH_MISALIGN_TRAP_EN
        repeat (12) do_cycle(1'b1, 1'b0, 32'd0);
        check_eq("halt_fault", 32'(fault), 32'd1);
        do_reset();
`else
        repeat (8) do_cycle(1'b1, 1'b0, 32'd0);
`endif

        // PC wrap past the top of the address space.
        do_cycle(1'b1, 1'b1, 32'hFFFF_FFF8);
        repeat (8) do_cycle(1'b1, 1'b0, 32'd0);

        // Randomized traffic.
        for (int i = 0; i < 3000; i++) begin
            if (i % 200 == 0) begin
                lat_min = 1;
                lat_max = int'($urandom_range(4, 1));
            end
            if (i % 750 == 749) do_reset();
            rpc = $urandom;
            if ($urandom_range(7, 0) == 0) rpc = 32'hFFFF_FFF0 | (rpc & 32'hF);
`ifdef FETCH_MISALIGN_TRAP_EN
            rpc = rpc & 32'hFFFF_FFFC;
`endif
            do_cycle($urandom_range(99, 0) < 70, $urandom_range(99, 0) < 5, rpc);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
